// File: rtl/vga_scan_gen.sv
// 640x480@60 scan generator: pixel clock, DrawX/DrawY coordinates, sync/blank
// outputs delayed PIPE pixel slots behind the coordinates, and per-frame strobes.
module vga_scan_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int PIPE      = 2
) (
    input  logic       Clk,
    input  logic       Reset_n,
    output logic       VGA_CLK,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       frame_start,
    output logic       vblank_start
);

    localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);
    // {hs, vs, blank_n} while idle: syncs released, picture blanked
    localparam logic [2:0] INACTIVE = 3'b110;

    logic       phase_reg;
    logic [9:0] h_cnt_reg, h_cnt_next;
    logic [9:0] v_cnt_reg, v_cnt_next;
    logic [2:0] raw_next;
    logic [2:0] stage0_reg;
    logic [2:0] tap;
    logic       frame_start_reg;
    logic       vblank_start_reg;

    // Counters move only in pixel slots (phase_reg high), i.e. on VGA_CLK falling edges.
    always_comb begin
        h_cnt_next = h_cnt_reg;
        v_cnt_next = v_cnt_reg;
        if (phase_reg) begin
            if (h_cnt_reg == H_LAST) begin
                h_cnt_next = 10'd0;
                v_cnt_next = (v_cnt_reg == V_LAST) ? 10'd0 : v_cnt_reg + 10'd1;
            end else begin
                h_cnt_next = h_cnt_reg + 10'd1;
            end
        end
    end

    // Raw timing is derived from the next position so depth 0 lines up with DrawX/DrawY.
    always_comb begin
        raw_next[2] = !((h_cnt_next >= HS_START) && (h_cnt_next < HS_END));
        raw_next[1] = !((v_cnt_next >= VS_START) && (v_cnt_next < VS_END));
        raw_next[0] = (h_cnt_next < H_VIS) && (v_cnt_next < V_VIS);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            phase_reg        <= 1'b0;
            h_cnt_reg        <= 10'd0;
            v_cnt_reg        <= 10'd0;
            stage0_reg       <= INACTIVE;
            frame_start_reg  <= 1'b0;
            vblank_start_reg <= 1'b0;
        end else begin
            phase_reg        <= ~phase_reg;
            h_cnt_reg        <= h_cnt_next;
            v_cnt_reg        <= v_cnt_next;
            if (phase_reg) begin
                stage0_reg <= raw_next;
            end
            frame_start_reg  <= phase_reg && (h_cnt_next == 10'd0) && (v_cnt_next == 10'd0);
            vblank_start_reg <= phase_reg && (h_cnt_next == 10'd0) && (v_cnt_next == V_VIS);
        end
    end

    generate
        if (PIPE == 0) begin : g_no_delay
            assign tap = stage0_reg;
        end else begin : g_delay
            localparam int SRW = 3 * PIPE;
            logic [SRW-1:0] sr_reg;

            // Oldest sample sits in the top three bits.
            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    sr_reg <= {PIPE{INACTIVE}};
                end else if (phase_reg) begin
                    sr_reg <= (sr_reg << 3) | SRW'(stage0_reg);
                end
            end

            assign tap = sr_reg[SRW-1 -: 3];
        end
    endgenerate

    assign VGA_CLK      = phase_reg;
    assign DrawX        = h_cnt_reg;
    assign DrawY        = v_cnt_reg;
    assign VGA_HS       = tap[2];
    assign VGA_VS       = tap[1];
    assign VGA_BLANK_N  = tap[0];
    assign VGA_SYNC_N   = 1'b0;
    assign frame_start  = frame_start_reg;
    assign vblank_start = vblank_start_reg;

endmodule
